// File: rtl/i2s_tx_param.sv
// Stereo serial-audio transmitter (I2S or left-justified) with MCLK/SCK generation,
// a one-entry sample holding register, mute and saturating underrun accounting.
module i2s_tx_param #(
    parameter int MCLK_HALF = 2,
    parameter int SCK_DIV   = 4,
    parameter int SLOT_W    = 16,
    parameter int SAMPLE_W  = 16,
    parameter int I2S_MODE  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [SAMPLE_W-1:0]         s_left,
    input  logic [SAMPLE_W-1:0]         s_right,
    input  logic                        mute,
    output logic                        mclk,
    output logic                        sck,
    output logic                        lrck,
    output logic                        sdout,
    output logic [$clog2(2*SLOT_W)-1:0] bit_idx,
    output logic                        underrun,
    output logic [7:0]                  underrun_cnt
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BW      = $clog2(FRAME_W);
    localparam int MW      = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int SW      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_HALF - 1);
    localparam logic [SW-1:0] SCK_LAST  = SW'(SCK_DIV - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(FRAME_W - 1);
    localparam logic [BW-1:0] B_LOAD    = BW'(I2S_MODE);
    localparam logic [BW-1:0] B_RIGHT   = BW'(SLOT_W);

    logic [MW-1:0]       mclk_cnt_q, mclk_cnt_d;
    logic [SW-1:0]       sck_cnt_q, sck_cnt_d;
    logic                mclk_q, sck_q, lrck_q, sdout_q, underrun_q;
    logic [BW-1:0]       b_q, b_d, pos;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_r_q;
    logic [7:0]          ucnt_q, ucnt_d;
    logic                mclk_tick, sck_tick, sck_fall, load, capture, underrun_d;

    // Samples sit MSB-aligned in their slot; the unused LSBs are zero.
    function automatic logic [SLOT_W-1:0] pad_slot(input logic [SAMPLE_W-1:0] x);
        return SLOT_W'(x) << (SLOT_W - SAMPLE_W);
    endfunction

    always_comb begin
        // Mixed-radix divider: the SCK stage only advances on MCLK half-period ticks,
        // which keeps both clocks phase-locked to one counter.
        mclk_tick  = (mclk_cnt_q == MCLK_LAST);
        sck_tick   = mclk_tick && (sck_cnt_q == SCK_LAST);
        sck_fall   = sck_tick && sck_q;
        mclk_cnt_d = mclk_tick ? '0 : mclk_cnt_q + MW'(1);
        sck_cnt_d  = sck_cnt_q;
        if (mclk_tick) begin
            sck_cnt_d = (sck_cnt_q == SCK_LAST) ? '0 : sck_cnt_q + SW'(1);
        end

        b_d = b_q;
        if (sck_fall) begin
            b_d = (b_q == B_LAST) ? '0 : b_q + BW'(1);
        end

        load       = sck_fall && (b_d == B_LOAD);
        capture    = s_valid && !hold_full_q;
        underrun_d = load && !hold_full_q;

        frame_d = frame_q;
        if (load) begin
            frame_d = (hold_full_q && !mute) ? {pad_slot(hold_l_q), pad_slot(hold_r_q)} : '0;
        end

        hold_full_d = hold_full_q;
        if (capture) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        ucnt_d = ucnt_q;
        if (underrun_d && (ucnt_q != 8'hFF)) begin
            ucnt_d = ucnt_q + 8'd1;
        end

        // Position within the serialised word lags b by the data delay, modulo the frame.
        if ((I2S_MODE != 0) && (b_d == '0)) begin
            pos = B_LAST;
        end else begin
            pos = b_d - B_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_cnt_q  <= '0;
            sck_cnt_q   <= '0;
            mclk_q      <= 1'b0;
            sck_q       <= 1'b0;
            b_q         <= '0;
            lrck_q      <= 1'b0;
            sdout_q     <= 1'b0;
            frame_q     <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            mclk_cnt_q  <= mclk_cnt_d;
            sck_cnt_q   <= sck_cnt_d;
            if (mclk_tick) begin
                mclk_q <= ~mclk_q;
            end
            if (sck_tick) begin
                sck_q <= ~sck_q;
            end
            b_q         <= b_d;
            lrck_q      <= (b_d >= B_RIGHT);
            sdout_q     <= frame_d[B_LAST - pos];
            frame_q     <= frame_d;
            hold_full_q <= hold_full_d;
            if (capture) begin
                hold_l_q <= s_left;
                hold_r_q <= s_right;
            end
            underrun_q  <= underrun_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign s_ready      = !hold_full_q;
    assign mclk         = mclk_q;
    assign sck          = sck_q;
    assign lrck         = lrck_q;
    assign sdout        = sdout_q;
    assign bit_idx      = b_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
endmodule

// File: tb/tb_i2s_tx_param.sv
// Bench for i2s_tx_param: a default-parameter I2S instance and a fast left-justified
// instance, each checked cycle by cycle against a timing/frame-queue reference model.
module tb_i2s_tx_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (I2S, 16-bit slots and samples)
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic        mute = 1'b0;
    logic        mclk, sck, lrck, sdout, underrun;
    logic [4:0]  bit_idx;
    logic [7:0]  underrun_cnt;

    // Fast left-justified instance with 12-bit samples in 16-bit slots
    logic        rst_lj = 1'b1;
    logic        lj_valid = 1'b0;
    logic        lj_ready;
    logic [11:0] lj_left = '0;
    logic [11:0] lj_right = '0;
    logic        lj_mute = 1'b0;
    logic        lj_mclk, lj_sck, lj_lrck, lj_sdout, lj_underrun;
    logic [4:0]  lj_bit_idx;
    logic [7:0]  lj_ucnt;

    i2s_tx_param u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .mute(mute),
        .mclk(mclk), .sck(sck), .lrck(lrck), .sdout(sdout),
        .bit_idx(bit_idx), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    i2s_tx_param #(
        .MCLK_HALF(1), .SCK_DIV(1), .SLOT_W(16), .SAMPLE_W(12), .I2S_MODE(0)
    ) u_lj (
        .clk(clk), .rst(rst_lj), .s_valid(lj_valid), .s_ready(lj_ready),
        .s_left(lj_left), .s_right(lj_right), .mute(lj_mute),
        .mclk(lj_mclk), .sck(lj_sck), .lrck(lj_lrck), .sdout(lj_sdout),
        .bit_idx(lj_bit_idx), .underrun(lj_underrun), .underrun_cnt(lj_ucnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the default instance: t counts clk edges since reset release.
    // With defaults: mclk half = 2, sck half = 8, one bit = 16, one frame = 512 clks.
    int          t = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_frame = '0;
    int          m_ucnt = 0;
    logic        e_mclk, e_sck, e_lrck, e_sdout, e_underrun, e_ready;
    int          e_b;

    task automatic step();
        logic cap, ld;
        logic [31:0] w;
        @(posedge clk);
        if (rst) begin
            t = 0;
            exp_q.delete();
            m_frame = '0;
            m_ucnt = 0;
            e_underrun = 1'b0;
        end else begin
            t++;
            cap = s_valid && (exp_q.size() == 0);
            ld = (t % 16 == 0) && ((t / 16) % 32 == 1);
            e_underrun = ld && (exp_q.size() == 0);
            if (ld) begin
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    m_frame = mute ? 32'd0 : w;
                end else begin
                    m_frame = '0;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
            if (cap) exp_q.push_back({s_left, s_right});
        end
        e_mclk  = ((t / 2) % 2) == 1;
        e_sck   = ((t / 8) % 2) == 1;
        e_b     = (t / 16) % 32;
        e_lrck  = e_b >= 16;
        e_sdout = m_frame[31 - ((e_b + 31) % 32)];
        e_ready = exp_q.size() == 0;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        mute = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({mclk, sck, lrck, sdout, underrun, s_ready, bit_idx, underrun_cnt} !==
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0}) begin
                errors++;
                $display("FAIL reset_state cycle=%0d got mclk=%b sck=%b lrck=%b sdout=%b ur=%b rdy=%b b=%0d cnt=%0d exp all 0, rdy=1",
                         i, mclk, sck, lrck, sdout, underrun, s_ready, bit_idx, underrun_cnt);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clocking();
        int   mr = -1, sr = -1, sf = -1, lr = -1, lf = -1;
        logic pm = 1'b0, ps = 1'b0, pl = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step();
            checks++;
            if ({mclk, sck, lrck, bit_idx} !== {e_mclk, e_sck, e_lrck, 5'(e_b)}) begin
                errors++;
                $display("FAIL clocking t=%0d got mclk/sck/lrck/b=%b/%b/%b/%0d exp %b/%b/%b/%0d",
                         t, mclk, sck, lrck, bit_idx, e_mclk, e_sck, e_lrck, e_b);
            end
            checks++;
            if (underrun !== e_underrun || underrun_cnt !== 8'(m_ucnt) || sdout !== 1'b0 || s_ready !== e_ready) begin
                errors++;
                $display("FAIL idle_frame t=%0d got ur=%b cnt=%0d sdout=%b rdy=%b exp ur=%b cnt=%0d sdout=0 rdy=%b",
                         t, underrun, underrun_cnt, sdout, s_ready, e_underrun, m_ucnt, e_ready);
            end
            checks++;
            if (lrck !== pl && (t % 16) != 0) begin
                errors++;
                $display("FAIL lrck_align t=%0d got lrck edge off a bit boundary exp edge only at t%%16==0", t);
            end
            if (t == 16) begin
                checks++;
                if (bit_idx !== 5'd1) begin
                    errors++;
                    $display("FAIL first_bit_idx got %0d exp 1", bit_idx);
                end
            end
            if (mclk === 1'b1 && pm === 1'b0 && mr < 0) mr = t;
            if (sck === 1'b1 && ps === 1'b0 && sr < 0) sr = t;
            if (sck === 1'b0 && ps === 1'b1 && sf < 0) sf = t;
            if (lrck === 1'b1 && pl === 1'b0 && lr < 0) lr = t;
            if (lrck === 1'b0 && pl === 1'b1 && lf < 0) lf = t;
            pm = mclk;
            ps = sck;
            pl = lrck;
        end
        checks++;
        if (mr != 2 || sr != 8 || sf != 16) begin
            errors++;
            $display("FAIL first_edges got mclk_rise=%0d sck_rise=%0d sck_fall=%0d exp 2/8/16", mr, sr, sf);
        end
        checks++;
        if (lr != 256 || lf != 512) begin
            errors++;
            $display("FAIL lrck_period got rise=%0d fall=%0d exp 256/512", lr, lf);
        end
    endtask

    task automatic test_i2s_data();
        logic [31:0] got = '0;
        do_reset(1);
        s_left  = 16'hA5C3;
        s_right = 16'h0F01;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL push_ready got %b exp 0", s_ready);
        end
        for (int i = 0; i < 560; i++) begin
            step();
            checks++;
            if (sdout !== e_sdout || s_ready !== e_ready || lrck !== e_lrck || underrun !== e_underrun) begin
                errors++;
                $display("FAIL i2s_data t=%0d got sdout=%b rdy=%b lrck=%b ur=%b exp %b/%b/%b/%b",
                         t, sdout, s_ready, lrck, underrun, e_sdout, e_ready, e_lrck, e_underrun);
            end
            if (t == 16) begin
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_load got %b exp 1", s_ready);
                end
            end
            if (t >= 16 && t <= 512 && (t % 16) == 0) got[31 - (t / 16 - 1)] = sdout;
        end
        checks++;
        if (got !== 32'hA5C30F01) begin
            errors++;
            $display("FAIL i2s_frame got %h exp a5c30f01", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b2, c, got1, got3;
        logic        zero_or;
        a = $urandom;
        b2 = $urandom;
        c = $urandom;
        got1 = '0;
        got3 = '0;
        zero_or = 1'b0;
        do_reset(1);
        mute = 1'b0;
        {s_left, s_right} = a;
        s_valid = 1'b1;
        while (t < 1600) begin
            step();
            checks++;
            if (sdout !== e_sdout || s_ready !== e_ready || underrun !== e_underrun || underrun_cnt !== 8'(m_ucnt)) begin
                errors++;
                $display("FAIL b2b_mute t=%0d got sdout=%b rdy=%b ur=%b cnt=%0d exp %b/%b/%b/%0d",
                         t, sdout, s_ready, underrun, underrun_cnt, e_sdout, e_ready, e_underrun, m_ucnt);
            end
            if (t == 16) begin
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_not_early got rdy=%b exp 1", s_ready);
                end
            end
            if (t == 17) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_accept got rdy=%b exp 0", s_ready);
                end
            end
            if (t == 528) begin
                checks++;
                if (underrun !== 1'b0 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL mute_load got ur=%b rdy=%b exp ur=0 rdy=1", underrun, s_ready);
                end
            end
            if (t >= 16 && t <= 512 && (t % 16) == 0) got1[31 - (t - 16) / 16] = sdout;
            if (t >= 528 && t <= 1024 && (t % 16) == 0) zero_or = zero_or | sdout;
            if (t >= 1040 && t <= 1536 && (t % 16) == 0) got3[31 - (t - 1040) / 16] = sdout;
            case (t)
                1:    {s_left, s_right} = b2;
                17:   s_valid = 1'b0;
                519:  mute = 1'b1;
                600: begin
                    mute = 1'b0;
                    {s_left, s_right} = c;
                    s_valid = 1'b1;
                end
                601:  s_valid = 1'b0;
                1200: mute = 1'b1;
                1500: mute = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (got1 !== a) begin
            errors++;
            $display("FAIL b2b_frame1 got %h exp %h", got1, a);
        end
        checks++;
        if (zero_or !== 1'b0) begin
            errors++;
            $display("FAIL muted_frame got nonzero bit exp all 0");
        end
        checks++;
        if (got3 !== c) begin
            errors++;
            $display("FAIL mute_midframe got %h exp %h", got3, c);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [31:0] x, y;
        x = $urandom;
        y = $urandom;
        do_reset(1);
        {s_left, s_right} = x;
        s_valid = 1'b1;
        while (t < 320) begin
            step();
            if (t == 1) s_valid = 1'b0;
            if (t == 16) begin
                {s_left, s_right} = y;
                s_valid = 1'b1;
            end
            if (t == 17) s_valid = 1'b0;
        end
        checks++;
        if (bit_idx !== 5'd20 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset got b=%0d rdy=%b exp b=20 rdy=0", bit_idx, s_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({mclk, sck, lrck, sdout, underrun, s_ready, bit_idx, underrun_cnt} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0}) begin
            errors++;
            $display("FAIL midframe_reset got mclk=%b sck=%b lrck=%b sdout=%b ur=%b rdy=%b b=%0d cnt=%0d exp all 0, rdy=1",
                     mclk, sck, lrck, sdout, underrun, s_ready, bit_idx, underrun_cnt);
        end
        for (int i = 0; i < 560; i++) begin
            step();
            checks++;
            if (sdout !== e_sdout || underrun !== e_underrun || underrun_cnt !== 8'(m_ucnt) || s_ready !== e_ready) begin
                errors++;
                $display("FAIL post_reset t=%0d got sdout=%b ur=%b cnt=%0d rdy=%b exp %b/%b/%0d/%b",
                         t, sdout, underrun, underrun_cnt, s_ready, e_sdout, e_underrun, m_ucnt, e_ready);
            end
            if (t == 16) begin
                checks++;
                if (underrun !== 1'b1 || sdout !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset_load got ur=%b sdout=%b exp ur=1 sdout=0", underrun, sdout);
                end
            end
            if (t == 17) begin
                checks++;
                if (underrun_cnt !== 8'd1 || underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset_count got cnt=%0d ur=%b exp cnt=1 ur=0", underrun_cnt, underrun);
                end
            end
        end
    endtask

    // Fast instance: mclk and sck toggle every clk, one bit = 2 clks, one frame = 64 clks,
    // load when b wraps to 0 (left-justified, no data delay).
    task automatic test_lj_underrun();
        int          lt, eb, ecnt, pulses;
        logic [31:0] lj_word;
        logic        e_lj_sdout, e_lj_ur;
        rst_lj = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_lj = 1'b0;
        lt = 0;
        pulses = 0;
        lj_left  = 12'h801;
        lj_right = 12'($urandom);
        lj_word  = {lj_left, 4'h0, lj_right, 4'h0};
        lj_valid = 1'b1;
        @(posedge clk);
        #1;
        lt++;
        lj_valid = 1'b0;
        checks++;
        if (lj_ready !== 1'b0) begin
            errors++;
            $display("FAIL lj_push_ready got %b exp 0", lj_ready);
        end
        while (lt < 64 * 302) begin
            @(posedge clk);
            #1;
            lt++;
            eb = (lt / 2) % 32;
            e_lj_sdout = (lt >= 64 && lt < 128) ? lj_word[31 - eb] : 1'b0;
            e_lj_ur = (lt % 64 == 0) && (lt >= 128);
            ecnt = (lt >= 128) ? ((lt / 64 - 1 > 255) ? 255 : lt / 64 - 1) : 0;
            if (lj_underrun === 1'b1) pulses++;
            checks++;
            if ({lj_mclk, lj_sck, lj_lrck, lj_bit_idx, lj_sdout} !==
                {1'(lt % 2), 1'(lt % 2), eb >= 16, 5'(eb), e_lj_sdout}) begin
                errors++;
                $display("FAIL lj_serial t=%0d got mclk/sck/lrck/b/sdout=%b/%b/%b/%0d/%b exp %0d/%0d/%b/%0d/%b",
                         lt, lj_mclk, lj_sck, lj_lrck, lj_bit_idx, lj_sdout, lt % 2, lt % 2, eb >= 16, eb, e_lj_sdout);
            end
            checks++;
            if (lj_underrun !== e_lj_ur || lj_ucnt !== 8'(ecnt)) begin
                errors++;
                $display("FAIL lj_underrun t=%0d got ur=%b cnt=%0d exp ur=%b cnt=%0d",
                         lt, lj_underrun, lj_ucnt, e_lj_ur, ecnt);
            end
            if (lt == 64 || lt == 86) begin
                checks++;
                if (lj_sdout !== 1'b1) begin
                    errors++;
                    $display("FAIL lj_pad_ones t=%0d got %b exp 1", lt, lj_sdout);
                end
            end
        end
        checks++;
        if (pulses != 301 || lj_ucnt !== 8'd255) begin
            errors++;
            $display("FAIL lj_saturate got pulses=%0d cnt=%0d exp 301/255", pulses, lj_ucnt);
        end
    endtask

    initial begin
        test_reset();
        test_clocking();
        test_i2s_data();
        test_back_to_back();
        test_mid_frame_reset();
        test_lj_underrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
